// File: rtl/tacho_gen_multi_pkg.sv
// ============================================================================
// Module      : tacho_pkg
// Description : Shared constants and state encoding for tacho_gen_multi.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package tacho_pkg;

    localparam logic [2:0] SEL_FSTEP = 3'd0;
    localparam logic [2:0] SEL_PHASE = 3'd1;
    localparam logic [2:0] SEL_MODE  = 3'd2;
    localparam logic [2:0] SEL_NUM   = 3'd3;
    localparam logic [2:0] SEL_INIT  = 3'd4;
    localparam logic [2:0] SEL_ZMARK = 3'd5;

    // A/B offset of a quarter period for a 32-bit accumulator
    localparam logic [31:0] QUARTER_PHASE = 32'h4000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tacho_gen_multi_chan.sv
// ============================================================================
// Module      : tacho_chan
// Description : One tacho channel: commit synchroniser, NCO, FSM, counter.
//               Zero-mark logic present only when TACHO_ZERO_MARK_EN is set.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tacho_chan
    import tacho_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             commit_req,
    input  logic [ACC_W-1:0] sh_fstep,
    input  logic [ACC_W-1:0] sh_phase,
    input  logic             sh_dir,
    input  logic             sh_limited,
    input  logic [NUM_W-1:0] sh_num,
    input  logic             init_we,
    input  logic [CNT_W-1:0] init_val,
`ifdef TACHO_ZERO_MARK_EN
    input  logic [15:0]      marks,
    output logic             zmark,
`endif
    output logic             spd_a,
    output logic             spd_b,
    output logic [CNT_W-1:0] count,
    output logic             finished
);

    state_t           state;
    state_t           state_next;
    logic [2:0]       commit_sync;
    logic             commit_pulse;
    logic [ACC_W-1:0] fstep;
    logic [ACC_W-1:0] phase;
    logic             dir;
    logic             limited;
    logic [NUM_W-1:0] remaining;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_lag;
    logic             a_raw;
    logic             b_raw;
    logic             a_prev;
    logic             count_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_sync <= '0;
        end else begin
            commit_sync <= {commit_sync[1:0], commit_req};
        end
    end

    assign commit_pulse = commit_sync[1] & ~commit_sync[2];
    assign acc_lag      = acc - phase;
    assign a_raw        = acc[ACC_W-1];
    assign b_raw        = acc_lag[ACC_W-1];
    assign finished     = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        count_edge = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                count_edge = (fstep != '0) && a_raw && !a_prev &&
                             !(limited && (remaining == '0));
                if (limited && (remaining == '0) && !commit_pulse) state_next = DONE;
            end
            DONE: begin
                // A zero-length limited commit keeps the channel parked
                if (commit_pulse && !(sh_limited && (sh_num == '0))) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
        if (!en) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fstep     <= '0;
            phase     <= '0;
            dir       <= 1'b0;
            limited   <= 1'b0;
            remaining <= '0;
        end else if (commit_pulse) begin
            fstep     <= sh_fstep;
            phase     <= sh_phase;
            dir       <= sh_dir;
            limited   <= sh_limited;
            remaining <= sh_num;
        end else if (count_edge && limited) begin
            remaining <= remaining - NUM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            a_prev <= 1'b0;
            spd_a  <= 1'b0;
            spd_b  <= 1'b0;
        end else begin
            a_prev <= a_raw;
            case (state)
                RUN: begin
                    acc <= acc + fstep;
                    if (fstep == '0) begin
                        spd_a <= 1'b0;
                        spd_b <= 1'b0;
                    end else begin
                        spd_a <= dir ? b_raw : a_raw;
                        spd_b <= dir ? a_raw : b_raw;
                    end
                end
                DONE: begin
                    spd_a <= dir;
                    spd_b <= ~dir;
                end
                default: begin
                    acc   <= '0;
                    spd_a <= 1'b1;
                    spd_b <= 1'b1;
                end
            endcase
            if (commit_pulse) acc <= '0;
        end
    end

    // Init-count write has priority over a coincident count edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (state == IDLE) begin
            count <= '0;
        end else if (init_we) begin
            count <= init_val;
        end else if (count_edge) begin
            count <= dir ? (count - CNT_W'(1)) : (count + CNT_W'(1));
        end
    end

`ifdef TACHO_ZERO_MARK_EN
    logic [15:0] rev_cnt;

    // The mark rises with A on the counted edge and falls with A
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rev_cnt <= '0;
            zmark   <= 1'b0;
        end else if ((state != RUN) || commit_pulse || (marks == '0)) begin
            rev_cnt <= '0;
            zmark   <= 1'b0;
        end else if (count_edge) begin
            if ((rev_cnt + 16'd1) == marks) begin
                rev_cnt <= '0;
                zmark   <= 1'b1;
            end else begin
                rev_cnt <= rev_cnt + 16'd1;
                zmark   <= 1'b0;
            end
        end else if (!a_raw) begin
            zmark <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/tacho_gen_multi.sv
// ============================================================================
// Module      : tacho_gen_multi
// Description : NCH-channel two-phase tachometer generator with shadow regs.
//               Optional zero-mark output enabled by TACHO_ZERO_MARK_EN.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tacho_gen_multi
    import tacho_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int ACC_W = 32,
    parameter int CNT_W = 32,
    parameter int NUM_W = 16,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 I_clk,
    input  logic                 I_reset_n,
    input  logic                 I_en,
    input  logic                 I_cfg_we,
    input  logic [CH_W-1:0]      I_cfg_ch,
    input  logic [2:0]           I_cfg_sel,
    input  logic [31:0]          I_cfg_data,
    input  logic [NCH-1:0]       I_commit,
    output logic [NCH-1:0]       O_spd_a,
    output logic [NCH-1:0]       O_spd_b,
    output logic [NCH*CNT_W-1:0] O_report_pulse,
`ifdef TACHO_ZERO_MARK_EN
    output logic [NCH-1:0]       O_zmark,
`endif
    output logic [NCH-1:0]       O_finished
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic             sel_ch;
        logic             init_we;
        logic [ACC_W-1:0] sh_fstep;
        logic [ACC_W-1:0] sh_phase;
        logic             sh_dir;
        logic             sh_limited;
        logic [NUM_W-1:0] sh_num;
`ifdef TACHO_ZERO_MARK_EN
        logic [15:0]      marks;
`endif

        assign sel_ch  = I_cfg_we && (I_cfg_ch == CH_W'(i));
        assign init_we = sel_ch && (I_cfg_sel == SEL_INIT);

        always_ff @(posedge I_clk or negedge I_reset_n) begin
            if (!I_reset_n) begin
                sh_fstep   <= '0;
                sh_phase   <= '0;
                sh_dir     <= 1'b0;
                sh_limited <= 1'b0;
                sh_num     <= '0;
`ifdef TACHO_ZERO_MARK_EN
                marks      <= '0;
`endif
            end else if (sel_ch) begin
                case (I_cfg_sel)
                    SEL_FSTEP: sh_fstep <= ACC_W'(I_cfg_data);
                    SEL_PHASE: sh_phase <= ACC_W'(I_cfg_data);
                    SEL_MODE: begin
                        sh_limited <= I_cfg_data[1];
                        sh_dir     <= I_cfg_data[0];
                    end
                    SEL_NUM:   sh_num <= NUM_W'(I_cfg_data);
`ifdef TACHO_ZERO_MARK_EN
                    SEL_ZMARK: marks <= I_cfg_data[15:0];
`endif
                    default: ;
                endcase
            end
        end

        tacho_chan #(
            .ACC_W (ACC_W),
            .CNT_W (CNT_W),
            .NUM_W (NUM_W)
        ) u_chan (
            .clk        (I_clk),
            .reset_n    (I_reset_n),
            .en         (I_en),
            .commit_req (I_commit[i]),
            .sh_fstep   (sh_fstep),
            .sh_phase   (sh_phase),
            .sh_dir     (sh_dir),
            .sh_limited (sh_limited),
            .sh_num     (sh_num),
            .init_we    (init_we),
            .init_val   (CNT_W'(I_cfg_data)),
`ifdef TACHO_ZERO_MARK_EN
            .marks      (marks),
            .zmark      (O_zmark[i]),
`endif
            .spd_a      (O_spd_a[i]),
            .spd_b      (O_spd_b[i]),
            .count      (O_report_pulse[i*CNT_W +: CNT_W]),
            .finished   (O_finished[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_tacho_gen_multi.sv
// ============================================================================
// Module      : tb_tacho_gen_multi
// Description : Directed self-checking bench for tacho_gen_multi.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tacho_gen_multi;
    import tacho_pkg::*;

    localparam int NCH   = 4;
    localparam int CNT_W = 32;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 en;
    logic                 cfg_we;
    logic [1:0]           cfg_ch;
    logic [2:0]           cfg_sel;
    logic [31:0]          cfg_data;
    logic [NCH-1:0]       commit_in;
    logic [NCH-1:0]       spd_a;
    logic [NCH-1:0]       spd_b;
    logic [NCH*CNT_W-1:0] report;
    logic [NCH-1:0]       finished;
`ifdef TACHO_ZERO_MARK_EN
    logic [NCH-1:0]       zmark;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    always #20 clk = ~clk;

    tacho_gen_multi #(
        .NCH   (NCH),
        .ACC_W (32),
        .CNT_W (CNT_W),
        .NUM_W (16)
    ) dut (
        .I_clk          (clk),
        .I_reset_n      (reset_n),
        .I_en           (en),
        .I_cfg_we       (cfg_we),
        .I_cfg_ch       (cfg_ch),
        .I_cfg_sel      (cfg_sel),
        .I_cfg_data     (cfg_data),
        .I_commit       (commit_in),
        .O_spd_a        (spd_a),
        .O_spd_b        (spd_b),
        .O_report_pulse (report),
`ifdef TACHO_ZERO_MARK_EN
        .O_zmark        (zmark),
`endif
        .O_finished     (finished)
    );

    task automatic push_exp(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] want;
        want = 64'hBAD0_BAD0_BAD0_BAD0;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return report[ch*CNT_W +: CNT_W];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input logic [2:0] sel, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_ch   = ch[1:0];
        cfg_sel  = sel;
        cfg_data = data;
        step(1);
        cfg_we   = 1'b0;
    endtask

    task automatic do_commit(input logic [NCH-1:0] mask);
        commit_in = mask;
        step(5);
        commit_in = '0;
        step(3);
    endtask

    task automatic setup_quad(input int ch, input logic [31:0] mode);
        cfg_write(ch, SEL_FSTEP, 32'h1000_0000);
        cfg_write(ch, SEL_PHASE, QUARTER_PHASE);
        cfg_write(ch, SEL_MODE, mode);
    endtask

    // Bounded wait for the next rising edge of A or B on one channel
    task automatic wait_rise(input logic is_b, input int ch, output int n);
        logic prev, cur, seen;
        prev = is_b ? spd_b[ch] : spd_a[ch];
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            step(1);
            n++;
            cur = is_b ? spd_b[ch] : spd_a[ch];
            if (cur && !prev) seen = 1'b1;
            prev = cur;
        end
        push_exp(1);
        check("rise_seen", seen);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int rises;
        logic prev_a;

        reset_n   = 1'b0;
        en        = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_sel   = '0;
        cfg_data  = '0;
        commit_in = '0;
        step(2);
        push_exp(0); check("reset_a", spd_a);
        push_exp(0); check("reset_b", spd_b);
        push_exp(0); check("reset_fin", finished);
        push_exp(0); check("reset_cnt", report);
        reset_n = 1'b1;
        step(3);
        push_exp(4'hF); check("idle_a", spd_a);
        push_exp(4'hF); check("idle_b", spd_b);

        // Quadrature, forward
        setup_quad(0, 32'd0);
        do_commit(4'b0001);
        en = 1'b1;
        step(160);
        push_exp(10); check("quad_cnt", cnt(0));
        wait_rise(1'b0, 0, n);
        wait_rise(1'b0, 0, n);
        push_exp(16); check("quad_period", n);
        wait_rise(1'b1, 0, n);
        push_exp(4); check("quad_b_lag", n);

        // Reverse direction from init count 100
        en = 1'b0;
        step(2);
        cfg_write(0, SEL_MODE, 32'd1);
        do_commit(4'b0001);
        en = 1'b1;
        step(1);
        cfg_write(0, SEL_INIT, 32'd100);
        step(158);
        push_exp(90); check("dir_cnt", cnt(0));
        wait_rise(1'b0, 0, n);
        wait_rise(1'b0, 0, n);
        push_exp(16); check("dir_period", n);
        wait_rise(1'b1, 0, n);
        push_exp(12); check("dir_b_after_a", n);
        en = 1'b0;
        step(2);
        en = 1'b1;
        step(1);
        wait_rise(1'b1, 0, n);
        push_exp(32'hFFFF_FFFF); check("dir_wrap", cnt(0));

        // Limited mode, five pulses
        en = 1'b0;
        step(2);
        cfg_write(0, SEL_MODE, 32'd2);
        cfg_write(0, SEL_NUM, 32'd5);
        do_commit(4'b0001);
        en = 1'b1;
        rises  = 0;
        prev_a = spd_a[0];
        for (int k = 0; k < 150; k++) begin
            step(1);
            if (spd_a[0] && !prev_a) rises++;
            prev_a = spd_a[0];
        end
        push_exp(5); check("lim_rises", rises);
        push_exp(5); check("lim_cnt", cnt(0));
        push_exp(1); check("lim_fin", finished[0]);
        push_exp(0); check("lim_a", spd_a[0]);
        push_exp(1); check("lim_b", spd_b[0]);

        // Back to RUN, then a zero-length limited commit
        cfg_write(0, SEL_MODE, 32'd0);
        do_commit(4'b0001);
        push_exp(0); check("rerun_fin", finished[0]);
        cfg_write(0, SEL_NUM, 32'd0);
        cfg_write(0, SEL_MODE, 32'd2);
        commit_in = 4'b0001;
        step(3);
        push_exp(0); check("num0_fin_early", finished[0]);
        step(1);
        push_exp(1); check("num0_fin", finished[0]);
        commit_in = '0;
        step(3);

        // Aligned restart of all channels
        en = 1'b0;
        step(2);
        cfg_write(0, SEL_MODE, 32'd0);
        for (int c = 1; c < NCH; c++) setup_quad(c, 32'd0);
        do_commit(4'hF);
        en = 1'b1;
        wait_rise(1'b0, 0, n);
        push_exp(4'hF); check("align_hi", spd_a);
        step(8);
        push_exp(4'h0); check("align_lo", spd_a);
        step(7);
        cfg_write(0, SEL_INIT, 32'd1234);
        push_exp(4'hF); check("init_edge_a", spd_a);
        push_exp(1234); check("init_wins", cnt(0));
        push_exp(2); check("init_other_ch", cnt(1));

        // Enable drop
        en = 1'b0;
        step(3);
        push_exp(4'hF); check("en_off_a", spd_a);
        push_exp(4'hF); check("en_off_b", spd_b);
        push_exp(0); check("en_off_cnt", report);
        push_exp(0); check("en_off_fin", finished);

        // Zero step: outputs low, no counting
        cfg_write(0, SEL_FSTEP, 32'd0);
        do_commit(4'b0001);
        en = 1'b1;
        step(40);
        push_exp(0); check("f0_a", spd_a[0]);
        push_exp(0); check("f0_b", spd_b[0]);
        push_exp(0); check("f0_cnt", cnt(0));

        // Asynchronous reset mid-run
        wait_rise(1'b0, 1, n);
        #5 reset_n = 1'b0;
        #1;
        push_exp(0); check("arst_a", spd_a);
        push_exp(0); check("arst_b", spd_b);
        push_exp(0); check("arst_cnt", report);
        push_exp(0); check("arst_fin", finished);
        en = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);

`ifdef TACHO_ZERO_MARK_EN
        setup_quad(0, 32'd0);
        cfg_write(0, SEL_ZMARK, 32'd4);
        do_commit(4'b0001);
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_rise(1'b0, 0, n);
            push_exp((k % 4) == 3); check("zmark_edge", zmark[0]);
        end
        step(7);
        push_exp(1); check("zmark_width_hi", zmark[0]);
        step(1);
        push_exp(0); check("zmark_width_lo", zmark[0]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tacho_gen_multi.md
Name: tacho_gen_multi

Overview:
- Multi-channel successor to the single-pair tachometer generator.
- Each of NCH channels produces a two-phase (A/B) pulse pair from a phase-accumulator NCO, with:
  - fractional frequency resolution
  - arbitrary A/B phase offset and a direction bit
  - an up/down report counter
  - optional limited-pulse mode
- Sits behind the CPU register bank. Drives tachometer outputs of the simulator board.

Parameters:
- NCH, 4, number of channels (1..16)
- ACC_W, 32, phase accumulator / frequency step / phase offset width
- CNT_W, 32, report pulse counter width
- NUM_W, 16, limited-mode pulse number width

Ports:
- I_clk  in  1  system clock (25 MHz)
- I_reset_n  in  1  reset
- I_en  in  1  global enable, active high
- I_cfg_we  in  1  shadow register write strobe, one cycle
- I_cfg_ch  in  clog2(NCH)  target channel
- I_cfg_sel  in  3  0=fstep, 1=phase[ACC_W-1:0], 2={limited,dir} in bits[1:0], 3=pulse number, 4=init count, 5=marks/rev (optional feature)
- I_cfg_data  in  32  write data
- I_commit  in  NCH  per-channel commit request, asynchronous to register writes, positive-edge valid
- O_spd_a  out  NCH  channel A outputs
- O_spd_b  out  NCH  channel B outputs
- O_report_pulse  out  NCH*CNT_W  packed counters, channel 0 in LSBs
- O_finished  out  NCH  limited-mode done flags

Behaviour:
- Reset and clock: reset I_reset_n, asynchronous, active-low; clock I_clk.
- Reset values:
  - all shadow/active registers 0; accumulators 0; counters 0
  - O_spd_a = O_spd_b = 0; O_finished = 0
  - state IDLE; limited = 0
- Shadow write (I_cfg_we): updates the shadow register for the selected sel/channel next cycle. Active values are unaffected, except sel=4.
- sel=4 (init count): written directly into the report counter one cycle later. It wins over a coincident count edge.
- I_commit[i] path:
  - 2-FF synchroniser, then rising-edge detect.
  - On the detected edge, active <= shadow (fstep, phase, dir, limited, remaining) for channel i, and acc_i <= 0.
  - Commit-to-effect latency is 3 clocks.
  - Several channels committing in the same cycle are applied simultaneously, which gives aligned restarts.
- Per-channel FSM:
  - IDLE: entered when I_en = 0. Outputs A = B = 1, acc = 0, counter = 0, O_finished = 0. Commits are still accepted. Leaves to RUN when I_en = 1.
  - RUN:
    - acc <= acc + fstep each clock, wrapping mod 2^ACC_W.
    - a_raw = acc[MSB]; b_raw = (acc - phase)[MSB]. A quarter period is phase = 2^(ACC_W-2).
    - dir = 0: A = a_raw, B = b_raw. dir = 1: outputs swapped.
    - Outputs are registered, one clock after acc.
    - fstep = 0: A = B = 0, no counting.
  - Counting:
    - Each rising edge of a_raw increments the counter (dir = 0) or decrements it (dir = 1), wrapping mod 2^CNT_W.
    - In limited mode, each such edge also decrements remaining; the edge that makes remaining reach 0 is still counted.
  - RUN -> DONE when limited = 1 and remaining = 0. A commit with limited = 1 and number = 0 enters DONE the cycle after commit.
  - DONE:
    - A = dir, B = ~dir; O_finished = 1.
    - acc frozen; counter holds, init-count writes still allowed.
    - A new commit returns to RUN, or stays in DONE if the committed number = 0.
  - Any state -> IDLE when I_en = 0.
- Commit in RUN: acc restarts from 0 and the counter is not cleared. An output glitch of at most one cycle is accepted.
- Reset mid-run: all channels return to reset values immediately, with no output stretching.

Optional Feature:
- Macro TACHO_ZERO_MARK_EN adds:
  - output O_zmark (NCH)
  - per-channel marks/rev register (sel=5, 16 bit; 0 = disabled)
  - a revolution counter of counted A edges
- With the macro: O_zmark[i] pulses high for one full A-high interval on every marks/rev-th counted edge. It is cleared on commit and IDLE.
- Without the macro: the port and logic are absent, and a sel=5 write is ignored.

Decomposition:
- Package tacho_pkg holds:
  - sel code localparams (SEL_FSTEP, SEL_PHASE, SEL_MODE, SEL_NUM, SEL_INIT, SEL_ZMARK)
  - state enum IDLE/RUN/DONE
  - QUARTER_PHASE constant
- Sub-module tacho_chan holds one channel: NCO, FSM, counter, commit synchroniser.
- The top level has shadow-register decode and a generate loop over NCH.

Test Plan:
- Quadrature, ch0: fstep=2^28, phase=2^30, dir=0, commit, I_en=1 -> A period 16 clk, B lags A by 4 clk, counter = 10 after 160 clk.
- Direction: same as above but dir=1, init count=100 -> A/B swapped, counter reaches 90 after 10 periods, and wraps 0 -> 2^32-1 from init 0.
- Limited mode: limited=1, number=5 -> exactly 5 counted edges, then A=0/B=1 and O_finished=1. Number=0 -> DONE 4 clk after commit edge.
- Simultaneous commit: ch0..3 committed together with identical fstep -> A edges cycle-aligned. Init-count write coincident with a count edge -> written value wins.
- Enable/reset: I_en dropped mid-run -> A=B=1, counters 0. I_reset_n asserted mid-run -> all outputs 0 asynchronously. fstep=0 -> A=B=0, counter static.
- TACHO_ZERO_MARK_EN: marks/rev=4 -> O_zmark high on every 4th counted A edge, for the A-high width.
